cache_tag_ctrl: RTL and testbench
=================================

Name: cache_tag_ctrl

Overview:
- Parametrised N-way set-associative tag store with hit detection, replacement choice and a flush engine, for the LC-3b cache datapath.
- Holds tag, valid and tree-PLRU state per set.
- Answers lookups one cycle after request with a one-hot hit vector, the hit way, and the victim way for a miss.
- Accepts fill writes from the cache controller and bulk invalidation (flush).

Parameters:
- WAYS, 4, associativity; power of two, 2..8
- SETS, 8, number of sets; power of two, 2..64
- TAG_W, 9, tag width in bits
- IDX_W, $clog2(SETS), set index width; derived, do not override
- WAY_W, $clog2(WAYS), way number width; derived, do not override

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- lkp_valid  in  1  lookup request strobe
- lkp_ready  out  1  lookup accepted this cycle (low while flushing)
- lkp_index  in  IDX_W  lookup set
- lkp_tag  in  TAG_W  lookup tag
- rsp_valid  out  1  registered lookup result valid (one cycle pulse)
- rsp_hit  out  1  any way hit
- rsp_hit_vec  out  WAYS  one-hot hit vector
- rsp_hit_way  out  WAY_W  binary hit way; 0 on miss
- rsp_victim  out  WAY_W  way to refill on miss
- rsp_multihit  out  1  more than one valid way matched (error)
- fill_valid  in  1  write tag into fill_index/fill_way, set valid
- fill_index  in  IDX_W  fill set
- fill_way  in  WAY_W  fill way
- fill_tag  in  TAG_W  fill tag
- flush_req  in  1  start invalidate-all (pulse)
- flush_busy  out  1  flush in progress

Behaviour:
- Reset (async, reset_n low):
  - all valid bits and PLRU bits clear; flush FSM to IDLE.
  - Outputs: rsp_* = 0, flush_busy = 0, lkp_ready = 1 once reset_n is high.
  - Tag storage is not reset.
- Lookup, latency 1:
  - Accepted when lkp_valid && lkp_ready.
  - Next cycle: rsp_valid = 1.
  - rsp_hit_vec[w] = valid[idx][w] && tag[idx][w] == lkp_tag.
  - rsp_hit = OR of rsp_hit_vec.
  - Multihit: rsp_hit_way = lowest matching way; rsp_hit_vec reports all matches; rsp_multihit = 1.
  - rsp_* outputs hold their last values when rsp_valid = 0.
- Victim choice, computed from the same pre-edge state:
  - lowest-numbered invalid way in the set;
  - else the PLRU victim.
  - rsp_victim is valid on hits too; the controller ignores it there.
- Tree-PLRU, WAYS-1 bits per set, node 0 = root, children of node n are 2n+1 and 2n+2:
  - bit = 0 means the victim lies in the lower half.
  - On access to way w, every node on w's path is set to point away from w.
  - After reset, victim = way 0.
- PLRU update events:
  - accepted lookup hit (hit way);
  - fill (fill_way).
  - A miss does not update PLRU.
- Fill:
  - Single cycle write at the edge: tag and valid = 1, PLRU updated.
  - Fill is ignored while flush_busy = 1.
- Simultaneous fill and lookup:
  - The lookup reads pre-edge state, so a fill is not visible to a lookup issued in the same cycle.
  - Same set: the fill's PLRU update wins and the hit update is dropped.
  - Different sets: both updates apply.
- Flush FSM states:
  - IDLE: flush_req -> CLEAR, counter = 0, flush_busy = 1.
  - CLEAR: clears valid and PLRU of set[counter] each cycle, counter++. After set SETS-1 -> IDLE; flush_busy drops the cycle after the last set is cleared.
  - Total flush_busy high: SETS cycles.
  - flush_req while busy: ignored, no restart.
  - lkp_ready = !flush_busy. A lookup accepted in the same cycle as flush_req completes against pre-flush state.
- Reset asserted mid-flush: immediate return to IDLE with all valid bits clear.
- Widths: the index counter wraps naturally at SETS; no out-of-range index is possible.

Test Plan:
- Reset, lookup set 3 tag 0x055 -> next cycle: rsp_valid = 1, rsp_hit = 0, rsp_victim = 0, rsp_multihit = 0.
- Fill set 3 ways 0..3 with tags 0x10..0x13, then lookup tag 0x12 -> rsp_hit = 1, rsp_hit_vec = 4'b0100, rsp_hit_way = 2.
- PLRU check:
  - after the four fills, next victim = 0;
  - lookups hitting ways 0 then 2 -> victim = 1;
  - then hit way 1 -> victim = 3.
- Same-cycle fill (set 5, way 1, tag 0x0AA) and lookup (set 5, tag 0x0AA) -> miss reported; repeat lookup next cycle -> hit, way 1.
- Force duplicate tag 0x07 in ways 1 and 3, lookup -> rsp_hit_way = 1, rsp_hit_vec = 4'b1010, rsp_multihit = 1.
- Flush with SETS = 8:
  - flush_busy is high exactly 8 cycles and lkp_ready is low throughout;
  - fills during the flush are ignored;
  - every set then misses.
  - Repeat with reset_n pulsed low at flush cycle 3 -> IDLE, all sets miss.

Source files
------------

// File: rtl/cache_tag_ctrl.sv
// N-way set-associative tag store for the LC-3b cache: hit detection, tree-PLRU
// victim selection, fill writes and a one-set-per-cycle flush engine.
module cache_tag_ctrl #(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    parameter int TAG_W = 9,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             lkp_valid,
    output logic             lkp_ready,
    input  logic [IDX_W-1:0] lkp_index,
    input  logic [TAG_W-1:0] lkp_tag,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [WAYS-1:0]  rsp_hit_vec,
    output logic [WAY_W-1:0] rsp_hit_way,
    output logic [WAY_W-1:0] rsp_victim,
    output logic             rsp_multihit,
    input  logic             fill_valid,
    input  logic [IDX_W-1:0] fill_index,
    input  logic [WAY_W-1:0] fill_way,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             flush_req,
    output logic             flush_busy
);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } flush_state_t;

    flush_state_t state, state_next;
    logic [IDX_W-1:0] flush_cnt, flush_cnt_next;

    logic [TAG_W-1:0]            tags [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]   valid_q;
    logic [SETS-1:0][WAYS-2:0]   plru_q;

    logic [WAYS-1:0]  set_valid;
    logic [WAYS-2:0]  set_plru;
    logic [WAYS-1:0]  hit_vec;
    logic             hit_any;
    logic             multihit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_way;
    logic             lkp_accept;
    logic             fill_en;
    logic             same_set;
    logic [WAYS-2:0]  hit_plru;
    logic [WAYS-2:0]  fill_plru;

    // Walk root to leaf along the way's bits, pointing each node at the other half.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] r;
        int node;
        r    = bits;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            r[node] = ~way[WAY_W-1-l];
            node    = 2 * node + 1 + int'(way[WAY_W-1-l]);
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        logic [WAY_W-1:0] v;
        int node;
        v    = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            v[WAY_W-1-l] = bits[node];
            node         = 2 * node + 1 + int'(bits[node]);
        end
        return v;
    endfunction

    assign flush_busy = (state == ST_CLEAR);
    assign lkp_ready  = !flush_busy;
    assign lkp_accept = lkp_valid && lkp_ready;
    assign fill_en    = fill_valid && !flush_busy;
    assign same_set   = fill_en && (fill_index == lkp_index);

    always_comb begin
        set_valid  = valid_q[lkp_index];
        set_plru   = plru_q[lkp_index];
        hit_vec    = '0;
        hit_way    = '0;
        victim_way = plru_victim(set_plru);
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = set_valid[w] && (tags[lkp_index][w] == lkp_tag);
        end
        // Descending scans so the lowest-numbered match / invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!set_valid[w]) begin
                victim_way = WAY_W'(w);
            end
        end
        hit_any  = |hit_vec;
        multihit = (hit_vec & (hit_vec - WAYS'(1))) != '0;
    end

    assign hit_plru  = plru_touch(set_plru, hit_way);
    assign fill_plru = plru_touch(plru_q[fill_index], fill_way);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            ST_IDLE: begin
                if (flush_req) begin
                    state_next     = ST_CLEAR;
                    flush_cnt_next = '0;
                end
            end
            ST_CLEAR: begin
                flush_cnt_next = flush_cnt + IDX_W'(1);
                if (flush_cnt == IDX_W'(SETS - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A same-set fill owns the PLRU write; the concurrent hit update is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            plru_q  <= '0;
        end else if (flush_busy) begin
            valid_q[flush_cnt] <= '0;
            plru_q[flush_cnt]  <= '0;
        end else begin
            if (lkp_accept && hit_any && !same_set) begin
                plru_q[lkp_index] <= hit_plru;
            end
            if (fill_en) begin
                valid_q[fill_index][fill_way] <= 1'b1;
                plru_q[fill_index]            <= fill_plru;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[fill_index][fill_way] <= fill_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid    <= 1'b0;
            rsp_hit      <= 1'b0;
            rsp_hit_vec  <= '0;
            rsp_hit_way  <= '0;
            rsp_victim   <= '0;
            rsp_multihit <= 1'b0;
        end else if (lkp_accept) begin
            rsp_valid    <= 1'b1;
            rsp_hit      <= hit_any;
            rsp_hit_vec  <= hit_vec;
            rsp_hit_way  <= hit_way;
            rsp_victim   <= victim_way;
            rsp_multihit <= multihit;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Self-checking bench for cache_tag_ctrl: directed scenarios plus random traffic
// checked every cycle against a range-based behavioural model of the tag store.
module tb_cache_tag_ctrl;

    localparam int WAYS  = 4;
    localparam int SETS  = 8;
    localparam int TAG_W = 9;
    localparam int IDX_W = 3;
    localparam int WAY_W = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             lkp_valid;
    logic             lkp_ready;
    logic [IDX_W-1:0] lkp_index;
    logic [TAG_W-1:0] lkp_tag;
    logic             rsp_valid;
    logic             rsp_hit;
    logic [WAYS-1:0]  rsp_hit_vec;
    logic [WAY_W-1:0] rsp_hit_way;
    logic [WAY_W-1:0] rsp_victim;
    logic             rsp_multihit;
    logic             fill_valid;
    logic [IDX_W-1:0] fill_index;
    logic [WAY_W-1:0] fill_way;
    logic [TAG_W-1:0] fill_tag;
    logic             flush_req;
    logic             flush_busy;

    always #5 clk = ~clk;

    cache_tag_ctrl #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_index(lkp_index), .lkp_tag(lkp_tag),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_hit_vec(rsp_hit_vec),
        .rsp_hit_way(rsp_hit_way), .rsp_victim(rsp_victim), .rsp_multihit(rsp_multihit),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way), .fill_tag(fill_tag),
        .flush_req(flush_req), .flush_busy(flush_busy)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: per-set arrays, PLRU tree walked as halving way ranges.
    bit               m_valid [SETS][WAYS];
    logic [TAG_W-1:0] m_tag   [SETS][WAYS];
    bit               m_plru  [SETS][WAYS-1];
    int               m_left;
    logic             e_valid, e_hit, e_multi;
    logic [WAYS-1:0]  e_vec;
    int               e_way, e_victim;
    bit               mv_busy, mv_acc, mv_fen, mv_found;
    int               mv_li, mv_fi, mv_fw, mv_n, mv_clr;

    function automatic int model_victim(input int s);
        int lo, hi, n, mid;
        lo = 0; hi = WAYS; n = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (!m_plru[s][n]) begin hi = mid; n = 2 * n + 1; end
            else begin lo = mid; n = 2 * n + 2; end
        end
        return lo;
    endfunction

    function automatic void model_touch(input int s, input int w);
        int lo, hi, n, mid;
        lo = 0; hi = WAYS; n = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w < mid) begin m_plru[s][n] = 1'b1; hi = mid; n = 2 * n + 1; end
            else begin m_plru[s][n] = 1'b0; lo = mid; n = 2 * n + 2; end
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
                for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 1'b0;
            end
            m_left = 0;
            e_valid = 1'b0; e_hit = 1'b0; e_multi = 1'b0; e_vec = '0; e_way = 0; e_victim = 0;
        end else begin
            mv_busy = (m_left > 0);
            mv_acc  = lkp_valid && !mv_busy;
            mv_fen  = fill_valid && !mv_busy;
            mv_li   = int'(lkp_index);
            mv_fi   = int'(fill_index);
            mv_fw   = int'(fill_way);
            e_valid = mv_acc;
            if (mv_acc) begin
                e_vec = '0; e_way = 0; mv_n = 0; mv_found = 1'b0;
                for (int w = 0; w < WAYS; w++) begin
                    if (m_valid[mv_li][w] && m_tag[mv_li][w] == lkp_tag) begin
                        e_vec[w] = 1'b1;
                        mv_n++;
                        if (mv_n == 1) e_way = w;
                    end
                end
                e_hit   = (mv_n > 0);
                e_multi = (mv_n > 1);
                e_victim = model_victim(mv_li);
                for (int w = 0; w < WAYS; w++) begin
                    if (!mv_found && !m_valid[mv_li][w]) begin e_victim = w; mv_found = 1'b1; end
                end
            end
            if (mv_busy) begin
                mv_clr = SETS - m_left;
                for (int w = 0; w < WAYS; w++) m_valid[mv_clr][w] = 1'b0;
                for (int n = 0; n < WAYS - 1; n++) m_plru[mv_clr][n] = 1'b0;
                m_left--;
            end else begin
                if (flush_req) m_left = SETS;
                if (mv_acc && e_hit && !(mv_fen && mv_fi == mv_li)) model_touch(mv_li, e_way);
                if (mv_fen) begin
                    m_tag[mv_fi][mv_fw]   = fill_tag;
                    m_valid[mv_fi][mv_fw] = 1'b1;
                    model_touch(mv_fi, mv_fw);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check_output("rsp_valid", rsp_valid, e_valid);
            check_output("rsp_hit", rsp_hit, e_hit);
            check_output("rsp_hit_vec", rsp_hit_vec, e_vec);
            check_output("rsp_hit_way", rsp_hit_way, e_way);
            check_output("rsp_victim", rsp_victim, e_victim);
            check_output("rsp_multihit", rsp_multihit, e_multi);
            check_output("flush_busy", flush_busy, m_left > 0);
            check_output("lkp_ready", lkp_ready, !(m_left > 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input bit lv, input int li, input int lt, input bit fv,
                                  input int fi, input int fw, input int ft, input bit fr);
        lkp_valid  = lv;
        lkp_index  = IDX_W'(li);
        lkp_tag    = TAG_W'(lt);
        fill_valid = fv;
        fill_index = IDX_W'(fi);
        fill_way   = WAY_W'(fw);
        fill_tag   = TAG_W'(ft);
        flush_req  = fr;
    endtask

    task automatic idle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_lookup(input int idx, input int tag);
        apply_stimulus(1, idx, tag, 0, 0, 0, 0, 0);
        tick();
        idle();
    endtask

    task automatic do_fill(input int idx, input int way, input int tag);
        apply_stimulus(0, 0, 0, 1, idx, way, tag, 0);
        tick();
        idle();
    endtask

    int probe_tag1 [SETS] = '{'h55, 'h55, 'h33, 'h10, 'h55, 'hAA, 'h07, 'h55};
    int probe_tag2 [SETS] = '{'h55, 'h44, 'h55, 'h12, 'h66, 'hAA, 'h07, 'h55};
    int tag_pool   [5]    = '{'h10, 'h11, 'h12, 'h13, 'h55};
    int busy_cycles;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        started = 1'b1;
        reset_n = 1'b1;
        tick();
        check_output("reset_rsp_valid", rsp_valid, 0);
        check_output("reset_flush_busy", flush_busy, 0);
        check_output("reset_lkp_ready", lkp_ready, 1);

        do_lookup(3, 'h055);
        check_output("cold_rsp_valid", rsp_valid, 1);
        check_output("cold_hit", rsp_hit, 0);
        check_output("cold_victim", rsp_victim, 0);
        check_output("cold_multihit", rsp_multihit, 0);

        for (int w = 0; w < 4; w++) do_fill(3, w, 'h10 + w);
        do_lookup(3, 'h1FF);
        check_output("plru_after_fills", rsp_victim, 0);
        do_lookup(3, 'h12);
        check_output("hit_flag", rsp_hit, 1);
        check_output("hit_vec", rsp_hit_vec, 4'b0100);
        check_output("hit_way", rsp_hit_way, 2);

        do_lookup(3, 'h10);
        do_lookup(3, 'h12);
        do_lookup(3, 'h1FF);
        check_output("plru_after_0_2", rsp_victim, 1);
        do_lookup(3, 'h11);
        do_lookup(3, 'h1FF);
        check_output("plru_after_1", rsp_victim, 3);

        apply_stimulus(1, 5, 'h0AA, 1, 5, 1, 'h0AA, 0);
        tick();
        idle();
        check_output("same_cycle_valid", rsp_valid, 1);
        check_output("same_cycle_miss", rsp_hit, 0);
        do_lookup(5, 'h0AA);
        check_output("after_fill_hit", rsp_hit, 1);
        check_output("after_fill_way", rsp_hit_way, 1);

        do_fill(6, 1, 'h07);
        do_fill(6, 3, 'h07);
        do_lookup(6, 'h07);
        check_output("multi_way", rsp_hit_way, 1);
        check_output("multi_vec", rsp_hit_vec, 4'b1010);
        check_output("multi_flag", rsp_multihit, 1);

        // Flush: fills and lookups offered throughout, plus a re-request mid-way.
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        busy_cycles = 0;
        while (flush_busy && busy_cycles < 20) begin
            check_output("ready_low_in_flush", lkp_ready, 0);
            apply_stimulus(1, 3, 'h10, 1, 2, 0, 'h33, busy_cycles == 3);
            busy_cycles++;
            tick();
        end
        idle();
        check_output("flush_busy_cycles", busy_cycles, SETS);
        for (int s = 0; s < SETS; s++) begin
            do_lookup(s, probe_tag1[s]);
            check_output("post_flush_miss", rsp_hit, 0);
        end

        do_fill(1, 2, 'h44);
        do_fill(4, 0, 'h66);
        do_fill(3, 3, 'h12);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_output("reset_aborts_flush", flush_busy, 0);
        tick();
        reset_n = 1'b1;
        tick();
        for (int s = 0; s < SETS; s++) begin
            do_lookup(s, probe_tag2[s]);
            check_output("post_reset_miss", rsp_hit, 0);
        end

        for (int i = 0; i < 600; i++) begin
            apply_stimulus($urandom_range(0, 1), $urandom_range(0, 3), tag_pool[$urandom_range(0, 4)],
                           $urandom_range(0, 9) < 3, $urandom_range(0, 3), $urandom_range(0, WAYS - 1),
                           tag_pool[$urandom_range(0, 4)], $urandom_range(0, 59) == 0);
            tick();
        end
        idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
